// File: rtl/seven_segment_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scan_decoder
//  Description : Recovers a 4-digit BCD value and decimal points from a
//                multiplexed, active-low seven-segment scan bus. Each digit
//                select must be stable for STABLE_CYCLES samples before it
//                is accepted; a frame is published once all four digits
//                have been captured. Optional hex-letter decoding is enabled
//                by defining the macro SEG_DECODE_HEX_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_segment_scan_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int SCAN_TIMEOUT  = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seven_segment_data,
   input  logic [3:0]  seven_segment_enable,
   output logic [15:0] bcd_digits,
   output logic [3:0]  dp,
   output logic        frame_valid,
   output logic        decode_err
);

   localparam int                 c_TO_W    = $clog2(SCAN_TIMEOUT + 1);
   localparam logic [7:0]         c_STABLE  = 8'(STABLE_CYCLES);
   localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(SCAN_TIMEOUT - 1);
   localparam logic [c_TO_W-1:0]  c_TO_SAT  = c_TO_W'(SCAN_TIMEOUT);
   localparam logic [c_TO_W-1:0]  c_TO_ONE  = c_TO_W'(1);

   typedef enum logic [0:0] {
      SYNC    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   // Segment pattern (active-high gfedcba) to digit; bit4 flags an unknown pattern.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      logic [4:0] v_res;
      case (seg)
         7'h3F:        v_res = {1'b0, 4'h0};
         7'h06:        v_res = {1'b0, 4'h1};
         7'h5B:        v_res = {1'b0, 4'h2};
         7'h4F:        v_res = {1'b0, 4'h3};
         7'h66:        v_res = {1'b0, 4'h4};
         7'h6D:        v_res = {1'b0, 4'h5};
         7'h7D:        v_res = {1'b0, 4'h6};
         7'h07, 7'h27: v_res = {1'b0, 4'h7};
         7'h7F:        v_res = {1'b0, 4'h8};
         7'h6F, 7'h67: v_res = {1'b0, 4'h9};
`ifdef SEG_DECODE_HEX_EN
         7'h77:        v_res = {1'b0, 4'hA};
         7'h7C:        v_res = {1'b0, 4'hB};
         7'h39:        v_res = {1'b0, 4'hC};
         7'h5E:        v_res = {1'b0, 4'hD};
         7'h79:        v_res = {1'b0, 4'hE};
         7'h71:        v_res = {1'b0, 4'hF};
`endif
         default:      v_res = {1'b1, 4'hF};
      endcase
      return v_res;
   endfunction

   // Input sample stage
   logic [7:0]        r_seg_s;
   logic [3:0]        r_en_s;
   // Run tracking
   logic [7:0]        r_seg_last;
   logic [3:0]        r_en_last;
   logic [7:0]        r_stab_cnt;
   // Frame assembly
   state_t            r_state;
   logic [3:0]        r_mask;
   logic [15:0]       r_shadow_val;
   logic [3:0]        r_shadow_dp;
   logic [c_TO_W-1:0] r_to_cnt;
   logic              r_load_pend;

   logic              w_sel;
   logic              w_blank;
   logic              w_illegal;
   logic              w_same;
   logic [1:0]        w_digit_idx;
   logic [7:0]        w_cnt_next;
   logic              w_accept;
   logic [3:0]        w_dec_val;
   logic              w_dec_unknown;
   logic              w_dp_lit;
   logic [3:0]        w_mask_next;

   // Register both bus inputs once; everything downstream works on this sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg_s <= 8'hFF;
         r_en_s  <= 4'hF;
      end else begin
         r_seg_s <= seven_segment_data;
         r_en_s  <= seven_segment_enable;
      end
   end

   // Classify the sampled enable, track run stability and decode the segments.
   always_comb begin
      w_sel       = 1'b0;
      w_digit_idx = 2'd0;
      case (r_en_s)
         4'b1110: begin w_sel = 1'b1; w_digit_idx = 2'd0; end
         4'b1101: begin w_sel = 1'b1; w_digit_idx = 2'd1; end
         4'b1011: begin w_sel = 1'b1; w_digit_idx = 2'd2; end
         4'b0111: begin w_sel = 1'b1; w_digit_idx = 2'd3; end
         default: ;
      endcase
      w_blank   = (r_en_s == 4'b1111);
      w_illegal = !w_sel && !w_blank;
      w_same    = (r_en_s == r_en_last) && (r_seg_s == r_seg_last);

      // A run restarts whenever the sample changes; the count holds at its limit.
      if (!w_sel) begin
         w_cnt_next = 8'd0;
      end else if (w_same && (r_stab_cnt != 8'd0)) begin
         w_cnt_next = (r_stab_cnt == c_STABLE) ? r_stab_cnt : r_stab_cnt + 8'd1;
      end else begin
         w_cnt_next = 8'd1;
      end

      // Accept exactly once per run: the first time the count hits the limit.
      w_accept = w_sel && (w_cnt_next == c_STABLE) &&
                 !(w_same && (r_stab_cnt == c_STABLE));

      {w_dec_unknown, w_dec_val} = seg_decode(~r_seg_s[6:0]);
      w_dp_lit    = ~r_seg_s[7];
      w_mask_next = r_mask | (4'b0001 << w_digit_idx);
   end

   // Remember the previous sample and the current run length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg_last <= 8'hFF;
         r_en_last  <= 4'hF;
         r_stab_cnt <= 8'd0;
      end else begin
         r_seg_last <= r_seg_s;
         r_en_last  <= r_en_s;
         r_stab_cnt <= w_cnt_next;
      end
   end

   // Frame FSM: gather digits into the shadow, publish a complete frame one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= SYNC;
         r_mask       <= 4'b0000;
         r_shadow_val <= 16'h0000;
         r_shadow_dp  <= 4'b0000;
         r_to_cnt     <= '0;
         r_load_pend  <= 1'b0;
         bcd_digits   <= 16'h0000;
         dp           <= 4'h0;
         frame_valid  <= 1'b0;
         decode_err   <= 1'b0;
      end else begin
         frame_valid <= r_load_pend;
         r_load_pend <= 1'b0;
         if (r_load_pend) begin
            bcd_digits <= r_shadow_val;
            dp         <= r_shadow_dp;
         end

         // Errors are reported independently of the frame state.
         decode_err <= w_illegal || (w_accept && w_dec_unknown);

         case (r_state)
            SYNC: begin
               r_to_cnt <= '0;
               if (w_accept && (w_digit_idx == 2'd0)) begin
                  r_shadow_val[3:0] <= w_dec_val;
                  r_shadow_dp[0]    <= w_dp_lit;
                  r_mask            <= 4'b0001;
                  r_state           <= COLLECT;
               end
            end
            COLLECT: begin
               if (w_accept) begin
                  r_to_cnt                                 <= '0;
                  r_shadow_val[{w_digit_idx, 2'b00} +: 4]  <= w_dec_val;
                  r_shadow_dp[w_digit_idx]                 <= w_dp_lit;
                  if (w_mask_next == 4'b1111) begin
                     r_load_pend <= 1'b1;
                     r_mask      <= 4'b0000;
                     r_state     <= SYNC;
                  end else begin
                     r_mask <= w_mask_next;
                  end
               end else if (r_to_cnt == c_TO_LAST) begin
                  // Scan stalled: drop the partial frame silently.
                  r_mask   <= 4'b0000;
                  r_to_cnt <= '0;
                  r_state  <= SYNC;
               end else if (r_to_cnt != c_TO_SAT) begin
                  r_to_cnt <= r_to_cnt + c_TO_ONE;
               end
            end
            default: begin
               r_state <= SYNC;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_segment_scan_decoder
//  Description : Scoreboard bench for seven_segment_scan_decoder. The driver
//                feeds a sample-by-sample reference model that pushes
//                expected frames; a monitor pops them on frame_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_segment_scan_decoder;

   localparam int c_STABLE  = 4;
   localparam int c_TIMEOUT = 60;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  seven_segment_data;
   logic [3:0]  seven_segment_enable;
   logic [15:0] bcd_digits;
   logic [3:0]  dp;
   logic        frame_valid;
   logic        decode_err;

   seven_segment_scan_decoder #(
      .STABLE_CYCLES (c_STABLE),
      .SCAN_TIMEOUT  (c_TIMEOUT)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .seven_segment_data   (seven_segment_data),
      .seven_segment_enable (seven_segment_enable),
      .bcd_digits           (bcd_digits),
      .dp                   (dp),
      .frame_valid          (frame_valid),
      .decode_err           (decode_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  dpv;
   } frame_t;

   frame_t exp_q[$];
   int     checks   = 0;
   int     failures = 0;
   int     exp_err  = 0;
   int     obs_err  = 0;
   int     cp_req   = 0;
   int     cp_done  = 0;
   frame_t mon_f;

   logic [6:0] digit_pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   logic [6:0] hex_pats   [6]  = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [6:0] stim_pats  [18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                   7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h67, 7'h27,
                                   7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // ---------------- reference model ----------------
   int         m_run;
   logic [3:0] m_last_en;
   logic [7:0] m_last_data;
   bit         m_collect;
   bit [3:0]   m_mask;
   logic [3:0] m_val [4];
   logic       m_dp  [4];
   int         m_gap;

   function automatic int sel_index(input logic [3:0] en);
      int n = 0;
      int idx = -1;
      for (int i = 0; i < 4; i++) if (!en[i]) begin n++; idx = i; end
      return (n == 1) ? idx : -1;
   endfunction

   function automatic bit ref_decode(input logic [6:0] pat, output logic [3:0] val);
      for (int d = 0; d < 10; d++) if (digit_pats[d] == pat) begin val = 4'(d); return 1'b1; end
      if (pat == 7'h67) begin val = 4'd9; return 1'b1; end
      if (pat == 7'h27) begin val = 4'd7; return 1'b1; end
`ifdef SEG_DECODE_HEX_EN
      for (int h = 0; h < 6; h++) if (hex_pats[h] == pat) begin val = 4'(10 + h); return 1'b1; end
`endif
      val = 4'hF;
      return 1'b0;
   endfunction

   function automatic void model_reset();
      m_run       = 0;
      m_last_en   = 4'hF;
      m_last_data = 8'hFF;
      m_collect   = 1'b0;
      m_mask      = 4'b0000;
      m_gap       = 0;
   endfunction

   function automatic void model_step(input logic [3:0] en, input logic [7:0] data);
      int         k = sel_index(en);
      bit         acc = 1'b0;
      logic [3:0] v;
      bit         known;
      frame_t     f;
      if (k < 0) begin
         if (en != 4'hF) exp_err++;
         m_run = 0;
      end else begin
         if (m_run > 0 && en == m_last_en && data == m_last_data) m_run++;
         else m_run = 1;
         acc = (m_run == c_STABLE);
      end
      m_last_en   = en;
      m_last_data = data;
      if (acc) begin
         known = ref_decode(~data[6:0], v);
         if (!known) exp_err++;
      end
      if (acc && (m_collect || k == 0)) begin
         if (!m_collect) begin m_collect = 1'b1; m_mask = 4'b0000; end
         m_val[k]  = v;
         m_dp[k]   = ~data[7];
         m_mask[k] = 1'b1;
         m_gap     = 0;
         if (m_mask == 4'hF) begin
            f.bcd = {m_val[3], m_val[2], m_val[1], m_val[0]};
            f.dpv = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
            exp_q.push_back(f);
            m_collect = 1'b0;
         end
      end else if (m_collect) begin
         m_gap++;
         if (m_gap >= c_TIMEOUT) m_collect = 1'b0;
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [3:0] en, input logic [7:0] data);
      @(negedge clk);
      seven_segment_enable = en;
      seven_segment_data   = data;
      model_step(en, data);
   endtask

   task automatic present(input logic [3:0] en, input logic [7:0] data, input int n);
      for (int i = 0; i < n; i++) drive(en, data);
   endtask

   task automatic scan4(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3, input int hold);
      present(4'b1110, d0, hold);
      present(4'b1101, d1, hold);
      present(4'b1011, d2, hold);
      present(4'b0111, d3, hold);
   endtask

   task automatic checkpoint();
      present(4'hF, 8'hFF, 8);
      cp_req++;
      present(4'hF, 8'hFF, 2);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_n                = 1'b0;
      seven_segment_enable = 4'hF;
      seven_segment_data   = 8'hFF;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [3:0] illegal_en();
      case ($urandom_range(0, 10))
         0:       return 4'b0000;
         1:       return 4'b0011;
         2:       return 4'b0101;
         3:       return 4'b0110;
         4:       return 4'b1001;
         5:       return 4'b1010;
         6:       return 4'b1100;
         7:       return 4'b0001;
         8:       return 4'b0010;
         9:       return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   function automatic logic [7:0] rand_data();
      logic [6:0] pat;
      logic       lit;
      int         i = int'($urandom_range(0, 19));
      if (i < 18) pat = stim_pats[i];
      else pat = 7'($urandom);
      lit = ($urandom_range(0, 4) == 0);
      return {~lit, ~pat};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         checks++;
         if (bcd_digits !== 16'h0 || dp !== 4'h0 || frame_valid !== 1'b0 || decode_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got bcd=%h dp=%b fv=%b err=%b, required all zero",
                     bcd_digits, dp, frame_valid, decode_err);
         end
      end else begin
         if (decode_err === 1'b1) obs_err++;
         if (frame_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL frame_unexpected: got bcd=%h dp=%b, required no frame", bcd_digits, dp);
            end else begin
               mon_f = exp_q.pop_front();
               if (bcd_digits !== mon_f.bcd || dp !== mon_f.dpv) begin
                  failures++;
                  $display("FAIL frame_content: got bcd=%h dp=%b, required bcd=%h dp=%b",
                           bcd_digits, dp, mon_f.bcd, mon_f.dpv);
               end
            end
         end
         if (cp_req != cp_done) begin
            cp_done = cp_req;
            checks++;
            if (obs_err != exp_err) begin
               failures++;
               $display("FAIL cp%0d_decode_err_count: got %0d, required %0d", cp_done, obs_err, exp_err);
            end
            checks++;
            if (exp_q.size() != 0) begin
               failures++;
               $display("FAIL cp%0d_missing_frames: got %0d outstanding, required 0", cp_done, exp_q.size());
               exp_q.delete();
            end
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int cur = 0;
      rst_n                = 1'b0;
      seven_segment_enable = 4'hF;
      seven_segment_data   = 8'hFF;
      model_reset();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;

      // Plain 4,3,2,1 scan
      scan4(8'h99, 8'hB0, 8'hA4, 8'hF9, 8);
      checkpoint();
      // Decimal point on digit2
      scan4(8'h99, 8'hB0, 8'h24, 8'hF9, 8);
      checkpoint();
      // One-cycle illegal enable mid-scan
      present(4'b1110, 8'h99, 8);
      present(4'b1101, 8'hB0, 8);
      present(4'b1100, 8'hB0, 1);
      present(4'b1011, 8'hA4, 8);
      present(4'b0111, 8'hF9, 8);
      checkpoint();
      // Digit1 too short, then re-presented
      present(4'b1110, 8'h99, 8);
      present(4'b1101, 8'hB0, 3);
      present(4'b1011, 8'hA4, 8);
      present(4'b0111, 8'hF9, 8);
      present(4'b1101, 8'hB0, 6);
      checkpoint();
      // Letter "A" on digit0
      scan4(8'h88, 8'hB0, 8'hA4, 8'hF9, 8);
      checkpoint();
      // Stalled scan is abandoned; later digits 2,3 ignored in SYNC
      present(4'b1110, 8'hC0, 6);
      present(4'b1101, 8'hF9, 6);
      present(4'hF, 8'hFF, 80);
      present(4'b1011, 8'hA4, 6);
      present(4'b0111, 8'hB0, 6);
      checkpoint();
      // Gap below the timeout keeps the partial frame
      present(4'b1110, 8'hC0, 6);
      present(4'b1101, 8'hF9, 6);
      present(4'hF, 8'hFF, 40);
      present(4'b1011, 8'hA4, 6);
      present(4'b0111, 8'hB0, 6);
      checkpoint();
      // Reset mid-frame, then 9,8,7,6
      present(4'b1110, 8'h99, 8);
      present(4'b1101, 8'hB0, 8);
      apply_reset();
      scan4(8'h90, 8'h80, 8'hF8, 8'h82, 8);
      checkpoint();

      // Randomised scanning with glitches, blanking and stalls
      for (int p = 0; p < 400; p++) begin
         int         r = int'($urandom_range(0, 99));
         int         k;
         logic [3:0] e;
         if (r < 6) begin
            present(illegal_en(), rand_data(), int'($urandom_range(1, 2)));
         end else if (r < 14) begin
            present(4'hF, 8'hFF, int'($urandom_range(1, 4)));
         end else if (r < 16) begin
            present(4'hF, 8'hFF, int'($urandom_range(62, 90)));
         end else begin
            k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : cur;
            e = 4'b1111;
            e[k] = 1'b0;
            present(e, rand_data(), int'($urandom_range(1, 7)));
            cur = (k + 1) % 4;
         end
         if (p % 50 == 49) checkpoint();
      end
      checkpoint();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_segment_scan_decoder.md
SEVEN_SEGMENT_SCAN_DECODER -- requirements
Module: seven_segment_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning consecutive identical samples needed before a digit is accepted (range 1..255).
REQ-002 Parameter SCAN_TIMEOUT, default 65535, meaning cycles without an accepted digit before the frame is abandoned.
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 seven_segment_data  input  8  multiplexed segment bus, active-low, bit7=dp, bit6..0=g,f,e,d,c,b,a.
REQ-006 seven_segment_enable  input  4  digit select, active-low, bit0=rightmost digit.
REQ-007 bcd_digits  output  16  last complete frame, digit0 in [3:0] ... digit3 in [15:12].
REQ-008 dp  output  4  decimal-point state per digit from last complete frame (1=lit).
REQ-009 frame_valid  output  1  one-cycle pulse when bcd_digits/dp update.
REQ-010 decode_err  output  1  one-cycle pulse on an illegal enable or unknown segment pattern.

Function
REQ-011 Both inputs SHALL be registered once before use; all latencies count from that sample register.
REQ-012 Enable value with exactly one bit low SHALL be a select; 4'b1111 SHALL be blanking (ignored, not an error); any other value SHALL pulse decode_err and reset the stability counter.
REQ-013 A select SHALL be accepted when enable and data are unchanged for STABLE_CYCLES consecutive samples; each select run is accepted at most once.
REQ-014 Segment decode (active-high view gfedcba): 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F; also 9 SHALL accept 67 and 7 SHALL accept 27.
REQ-015 An unknown pattern SHALL store 4'hF for that digit and pulse decode_err in the acceptance cycle.
REQ-016 FSM states: SYNC, COLLECT.
REQ-017 SYNC: wait for accepted digit0; store it, clear captured mask to 4'b0001, go COLLECT.
REQ-018 COLLECT: accepted digit k SHALL store into shadow slot k and set mask bit k; re-accepting an already-set digit SHALL overwrite the slot.
REQ-019 When mask reaches 4'b1111, bcd_digits/dp SHALL load from shadow and frame_valid SHALL pulse in the next cycle; FSM returns to SYNC.
REQ-020 No accepted digit for SCAN_TIMEOUT cycles in COLLECT SHALL return to SYNC without updating outputs or pulsing anything.
REQ-021 Stability counter SHALL saturate at STABLE_CYCLES; timeout counter SHALL saturate and never wrap.
REQ-022 Simultaneous illegal enable and timeout expiry: both take effect (decode_err pulses, FSM to SYNC).

Reset
REQ-023 rst_n low SHALL immediately force bcd_digits=16'h0000, dp=4'h0, frame_valid=0, decode_err=0, FSM=SYNC, mask and counters cleared.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; first post-reset frame starts at digit0.

Configuration
REQ-025 Macro SEG_DECODE_HEX_EN defined: patterns A=77,b=7C,C=39,d=5E,E=79,F=71 SHALL decode to 4'hA..4'hF without decode_err.
REQ-026 Macro SEG_DECODE_HEX_EN undefined: those patterns SHALL be treated as unknown per REQ-015.

Verification
REQ-027 Scan digits 0..3 showing 4,3,2,1 (data 8'h99,8'hB0,8'hA4,8'hF9), 8 cycles each, STABLE_CYCLES=4 -> one frame_valid, bcd_digits=16'h1234, dp=0, no decode_err.
REQ-028 Same scan with digit2 dp bit low (8'h24) -> bcd_digits=16'h1234, dp=4'b0100.
REQ-029 Enable 4'b1100 for 1 cycle mid-scan -> one decode_err pulse; frame still completes only after all four digits accepted.
REQ-030 Digit1 held only 3 cycles (STABLE_CYCLES=4) -> no frame_valid until digit1 re-presented for 4+ cycles.
REQ-031 Data 8'h88 ("A") on digit0 -> with SEG_DECODE_HEX_EN: digit0=4'hA, no error; without: digit0=4'hF plus decode_err pulse.
REQ-032 rst_n low after digits 0,1 accepted, then full scan 9,8,7,6 -> outputs 0 during reset; single frame with bcd_digits=16'h6789.
